fp_operand_loader: RTL and testbench
====================================

# fp_operand_loader

Operand entry stage directly upstream of the floating-point add/subtract FSM. Assembles two IEEE-754 single-precision operands, A and B, byte by byte from 8 switches and a raw "save" push-button. Presents both operands as stable 32-bit words and issues a one-cycle `start` pulse when the user leaves data-entry mode with both operands complete. Replaces the accumulate-on-button-edge loading with clean, synchronous, overwrite-per-byte storage.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before the synchronized button level is accepted; legal range 2..2^24-1.
- `clk` input 1: single system clock; all flops on its rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0), released synchronously by the board reset logic.
- `save` input 1: raw, asynchronous button; each press commits one byte.
- `datawork` input 1: raw slide switch; 1 = data entry, 0 = compute.
- `selnum` input 1: operand select; 0 = A, 1 = B.
- `seldata` input 2: byte index; 0 = bits [7:0] … 3 = bits [31:24].
- `datain` input 8: byte value.
- `op_a` output 32: operand A.
- `op_b` output 32: operand B.
- `loaded` output 8: per-byte loaded mask; bits [3:0] = A bytes 0..3, [7:4] = B bytes 0..3. Drives board LEDs.
- `start` output 1: one-cycle pulse to the downstream adder.
- `busy` output 1: high while operands are frozen for computation.
- `err` output 1: one-cycle pulse when compute is requested with an incomplete mask.

## Operation
- Input conditioning:
  - `save` and `datawork` each pass through a 2-flop synchronizer.
  - `save` is then debounced: the counter resets whenever the synchronized level equals the debounced level. The debounced level takes the synchronized value once the two have differed for `DEBOUNCE_CYCLES` consecutive cycles.
  - A rising edge of debounced save produces the registered `commit` pulse.
  - `datawork` is not debounced; its synchronized falling edge produces `go`.
- States: LOAD, ISSUE, HOLD.
- LOAD:
  - On `commit` with synchronized `datawork`=1: `datain` overwrites byte `seldata` of the operand selected by `selnum`, and the matching `loaded` bit is set.
  - `datain`/`selnum`/`seldata` are sampled at the commit edge only and are otherwise ignored.
  - On `go`: if `loaded`==8'hFF, go to ISSUE. Otherwise pulse `err` for one cycle and stay in LOAD.
- ISSUE: `start`=1 for exactly one cycle; `busy`=1; go to HOLD.
- HOLD:
  - `busy`=1; `op_a`, `op_b` and `loaded` are frozen and commits are dropped.
  - On synchronized `datawork` rising, go to LOAD.
  - Operand values and `loaded` are retained, so single bytes can be edited and the operation re-run.
- Simultaneous events:
  - `commit` and `go` in the same cycle: `go` is evaluated against the mask before the write, and the commit is dropped because synchronized `datawork` is 0.
  - Rewriting an already loaded byte overwrites it; the mask is unchanged.
- Reset, asynchronous and any time including mid-ISSUE/HOLD:
  - `op_a`=`op_b`=0, `loaded`=0, `start`=`busy`=`err`=0.
  - State LOAD; synchronizers, debounce counter and debounced level cleared to 0.

## Timing
- Raw `save` rising, held stable, until operand byte updated:
  - Debounce enabled: 2 (sync) + `DEBOUNCE_CYCLES` + 1 (commit register) + 1 (write) = `DEBOUNCE_CYCLES`+4 cycles.
  - Debounce disabled: 4 cycles.
- `loaded` updates in the same cycle as the byte.
- Raw `datawork` falling until `start` high: 4 cycles (2 sync, 1 edge/`go` register, 1 ISSUE).
- `err` follows the same latency, in place of `start`.
- `op_a`/`op_b` are stable from at least one cycle before `start` until leaving HOLD.
- Button bounces shorter than `DEBOUNCE_CYCLES` produce no commit. A single press held any duration produces exactly one commit. Release produces none.

## Configuration
- `LOADER_DEBOUNCE_EN` defined: the debounce counter is built as above.
- Macro undefined: the debounced level equals the synchronized level, no counter is instantiated, and `DEBOUNCE_CYCLES` is ignored. Used for simulation and for manual-clock bring-up.

## Structure
- Package `fp_loader_pkg`:
  - `loader_state_t` enum (LOAD, ISSUE, HOLD).
  - `byte_idx_t` (2-bit).
  - `MASK_FULL` = 8'hFF.
  - `fp32_t` packed struct {sign, exp[7:0], man[22:0]}, shared with the downstream adder.
- Sub-module `btn_debounce`: synchronizer, counter (under `LOADER_DEBOUNCE_EN`) and rising-edge pulse. Instantiated once for `save`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 with the macro defined.
- Reset released: all outputs 0 and state LOAD. Assert `reset`=0 during HOLD → outputs 0 asynchronously, before the next edge.
- Load A=32'h3FC00000 and B=32'h40200000 via 8 clean presses, then drop `datawork` → `op_a`/`op_b` match, `loaded`=8'hFF, `start` high exactly 1 cycle, 4 cycles after the `datawork` fall.
- Bounce `save` high/low in 2-cycle bursts for 20 cycles, then hold it high → exactly one byte write, `DEBOUNCE_CYCLES`+4 cycles after the final rise.
- Load only 7 bytes, then drop `datawork` → `err` 1-cycle pulse, no `start`, `busy`=0.
- In HOLD, press `save` with `datain`=8'hAA → no operand change. Raise `datawork`, write A byte 3 = 8'hC0, drop `datawork` → `op_a`=32'hC0C00000 and a second `start`.
- Macro undefined: press-to-write latency is 4 cycles.

Source files
------------

// File: rtl/fp_loader_pkg.sv
// Shared types and helpers for the floating-point operand loader and the
// downstream add/subtract datapath.
package fp_loader_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } loader_state_t;

    typedef logic [1:0] byte_idx_t;

    localparam logic [7:0] MASK_FULL = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    // Replace one byte of a 32-bit word, leaving the other three untouched.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input byte_idx_t   idx,
                                             input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    // Loaded-mask bit for operand sel (0 = A, 1 = B) and byte idx.
    function automatic logic [7:0] mask_bit(input logic sel, input byte_idx_t idx);
        logic [2:0] pos;
        pos = {sel, idx};
        return 8'(8'd1 << pos);
    endfunction

endpackage

// File: rtl/fp_operand_loader_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, optional debounce counter
// (built only when LOADER_DEBOUNCE_EN is defined) and a registered rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic level_s;
    logic level_prev_q;
    logic rise_q;

    // Two-flop synchronizer for the raw asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 32'd1);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic        level_q;
    logic        level_d;

    // Accept the synchronized level only after it has disagreed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = 24'd0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = 24'd0;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // Debounce counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 24'd0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_s = level_q;
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign level_s = sync2_q;
`endif

    // Registered rising-edge detector on the conditioned level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            level_prev_q <= level_s;
            rise_q       <= level_s & ~level_prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/fp_operand_loader.sv
// Byte-wise operand entry for the FP add/subtract FSM; LOADER_DEBOUNCE_EN
// selects whether the save button is debounced.
module fp_operand_loader
    import fp_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        save,
    input  logic        datawork,
    input  logic        selnum,
    input  logic [1:0]  seldata,
    input  logic [7:0]  datain,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [7:0]  loaded,
    output logic        start,
    output logic        busy,
    output logic        err
);

    loader_state_t state_q;
    loader_state_t state_d;

    logic dw_sync1_q;
    logic dw_sync2_q;
    logic dw_prev_q;
    logic go_q;
    logic dw_rise_s;
    logic commit_s;
    logic write_s;

    fp32_t      op_a_q;
    fp32_t      op_a_d;
    fp32_t      op_b_q;
    fp32_t      op_b_d;
    logic [7:0] loaded_q;
    logic [7:0] loaded_d;
    logic       start_q;
    logic       start_d;
    logic       busy_q;
    logic       busy_d;
    logic       err_q;
    logic       err_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_save_debounce (
        .clk    (clk),
        .rst_n  (reset),
        .btn_i  (save),
        .rise_o (commit_s)
    );

    // The mode switch is only synchronized; its falling edge becomes the registered go pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dw_sync1_q <= 1'b0;
            dw_sync2_q <= 1'b0;
            dw_prev_q  <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            dw_sync1_q <= datawork;
            dw_sync2_q <= dw_sync1_q;
            dw_prev_q  <= dw_sync2_q;
            go_q       <= dw_prev_q & ~dw_sync2_q;
        end
    end

    assign dw_rise_s = dw_sync2_q & ~dw_prev_q;
    assign write_s   = (state_q == LOAD) & commit_s & dw_sync2_q;

    // State register together with all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOAD;
            op_a_q   <= '0;
            op_b_q   <= '0;
            loaded_q <= 8'h00;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            loaded_q <= loaded_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; go is judged against the mask as it stood before any same-cycle write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (go_q && (loaded_q == MASK_FULL)) begin
                    state_d = ISSUE;
                end else begin
                    state_d = LOAD;
                end
            end
            ISSUE: state_d = HOLD;
            HOLD: begin
                if (dw_rise_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Output logic: flags are computed from the upcoming state so they land with it.
    always_comb begin
        start_d = (state_d == ISSUE);
        busy_d  = (state_d != LOAD);
        if ((state_q == LOAD) && go_q && (loaded_q != MASK_FULL)) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end
    end

    // Operand storage: each commit overwrites one byte and marks it loaded.
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        loaded_d = loaded_q;
        if (write_s) begin
            if (selnum) begin
                op_b_d = fp32_t'(put_byte(op_b_q, seldata, datain));
            end else begin
                op_a_d = fp32_t'(put_byte(op_a_q, seldata, datain));
            end
            loaded_d = loaded_q | mask_bit(selnum, seldata);
        end else begin
            loaded_d = loaded_q;
        end
    end

    assign op_a   = op_a_q;
    assign op_b   = op_b_q;
    assign loaded = loaded_q;
    assign start  = start_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed self-checking bench for fp_operand_loader (DEBOUNCE_CYCLES = 4).
module tb_fp_operand_loader;

    localparam int DEB = 4;
`ifdef LOADER_DEBOUNCE_EN
    localparam int LAT = DEB + 4;
    localparam logic [7:0]  BOUNCE_PRE_MASK = 8'h7F;
    localparam logic [31:0] BOUNCE_PRE_B    = 32'h00200000;
`else
    localparam int LAT = 4;
    localparam logic [7:0]  BOUNCE_PRE_MASK = 8'hFF;
    localparam logic [31:0] BOUNCE_PRE_B    = 32'h40200000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        save;
    logic        datawork;
    logic        selnum;
    logic [1:0]  seldata;
    logic [7:0]  datain;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [7:0]  loaded;
    logic        start;
    logic        busy;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    fp_operand_loader #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk      (clk),
        .reset    (reset),
        .save     (save),
        .datawork (datawork),
        .selnum   (selnum),
        .seldata  (seldata),
        .datain   (datain),
        .op_a     (op_a),
        .op_b     (op_b),
        .loaded   (loaded),
        .start    (start),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic press(input logic sel, input logic [1:0] idx, input logic [7:0] data);
        selnum  = sel;
        seldata = idx;
        datain  = data;
        save    = 1'b1;
        step(LAT + 2);
        save = 1'b0;
        step(LAT + 2);
    endtask

    initial begin
        reset = 1'b0; save = 1'b0; datawork = 1'b1;
        selnum = 1'b0; seldata = 2'd0; datain = 8'h00;
        step(3);
        reset = 1'b1;
        step(1);
        check("rst_op_a", op_a, 32'h0);
        check("rst_op_b", op_b, 32'h0);
        check("rst_loaded", {24'h0, loaded}, 32'h0);
        check("rst_start", {31'h0, start}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        step(4);

        // Timed press: A byte 2 = C0
        selnum = 1'b0; seldata = 2'd2; datain = 8'hC0; save = 1'b1;
        step(LAT - 1);
        check("press_pre_op_a", op_a, 32'h0);
        check("press_pre_loaded", {24'h0, loaded}, 32'h0);
        step(1);
        check("press_op_a", op_a, 32'h00C00000);
        check("press_loaded", {24'h0, loaded}, 32'h04);
        save = 1'b0;
        step(LAT + 2);

        press(1'b0, 2'd0, 8'h00);
        press(1'b0, 2'd1, 8'h00);
        press(1'b0, 2'd3, 8'h3F);
        press(1'b1, 2'd0, 8'h00);
        press(1'b1, 2'd1, 8'h00);
        press(1'b1, 2'd2, 8'h20);
        check("seven_loaded", {24'h0, loaded}, 32'h7F);
        check("seven_op_a", op_a, 32'h3FC00000);

        // Incomplete mask -> err pulse
        datawork = 1'b0;
        step(3);
        check("err_pre", {31'h0, err}, 32'h0);
        step(1);
        check("err_pulse", {31'h0, err}, 32'h1);
        check("err_no_start", {31'h0, start}, 32'h0);
        check("err_busy", {31'h0, busy}, 32'h0);
        step(1);
        check("err_end", {31'h0, err}, 32'h0);
        check("err_stay_busy", {31'h0, busy}, 32'h0);
        datawork = 1'b1;
        step(4);

        // Bouncy press of B byte 3 = 40
        selnum = 1'b1; seldata = 2'd3; datain = 8'h40;
        for (int i = 0; i < 5; i++) begin
            save = 1'b1;
            step(2);
            save = 1'b0;
            step(2);
        end
        save = 1'b1;
        step(LAT - 1);
        check("bounce_pre_loaded", {24'h0, loaded}, {24'h0, BOUNCE_PRE_MASK});
        check("bounce_pre_op_b", op_b, BOUNCE_PRE_B);
        step(1);
        check("bounce_loaded", {24'h0, loaded}, 32'hFF);
        check("bounce_op_b", op_b, 32'h40200000);
        save = 1'b0;
        step(LAT + 2);

        // Complete mask -> start pulse
        datawork = 1'b0;
        step(3);
        check("start_pre", {31'h0, start}, 32'h0);
        step(1);
        check("start_pulse", {31'h0, start}, 32'h1);
        check("start_busy", {31'h0, busy}, 32'h1);
        check("start_op_a", op_a, 32'h3FC00000);
        check("start_op_b", op_b, 32'h40200000);
        check("start_err", {31'h0, err}, 32'h0);
        step(1);
        check("start_end", {31'h0, start}, 32'h0);
        check("hold_busy", {31'h0, busy}, 32'h1);

        // Press during HOLD is dropped
        press(1'b0, 2'd0, 8'hAA);
        check("hold_op_a", op_a, 32'h3FC00000);
        check("hold_loaded", {24'h0, loaded}, 32'hFF);
        check("hold_busy2", {31'h0, busy}, 32'h1);

        // Back to LOAD, edit A byte 3, rerun
        datawork = 1'b1;
        step(4);
        check("reload_busy", {31'h0, busy}, 32'h0);
        press(1'b0, 2'd3, 8'hC0);
        check("edit_op_a", op_a, 32'hC0C00000);
        check("edit_loaded", {24'h0, loaded}, 32'hFF);
        datawork = 1'b0;
        step(4);
        check("rerun_start", {31'h0, start}, 32'h1);
        check("rerun_op_a", op_a, 32'hC0C00000);
        step(1);
        check("rerun_start_end", {31'h0, start}, 32'h0);
        check("rerun_busy", {31'h0, busy}, 32'h1);

        // Asynchronous reset during HOLD
        step(2);
        reset = 1'b0;
        #2;
        check("async_op_a", op_a, 32'h0);
        check("async_op_b", op_b, 32'h0);
        check("async_loaded", {24'h0, loaded}, 32'h0);
        check("async_busy", {31'h0, busy}, 32'h0);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
